// File: rtl/mem_pkg.sv
// mem_pkg: state type, byte-mask constants and merge helper
// shared by the RAM arbiter and its round-robin sub-block.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef DATA_ZERO
`define DATA_ZERO 32'h0000_0000
`endif

package mem_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } ram_arb_state_e;

    localparam logic [3:0] MASK_FULL = 4'b1111;
    localparam logic [3:0] MASK_NONE = 4'b0000;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  mask
    );
        logic [31:0] m;
        m = old_w;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) m[8*i +: 8] = new_w[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way round-robin arbiter; the pointer names the
// side that wins a tie and flips to the loser after each grant.
module arb_rr2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    assign ptr_d = adv_i ? gnt_o[0] : ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= 1'b0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one byte-enable-less RAM between IFU and LSU,
// emulating partial stores with a read-modify-write.
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = `ADDR_WIDTH,
    parameter int DATA_W = `DATA_WIDTH
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst_n,
    input  logic              i_ifu_req_valid,
    output logic              o_ifu_req_ready,
    input  logic [ADDR_W-1:0] i_ifu_req_addr,
    output logic              o_ifu_rsp_valid,
    output logic [DATA_W-1:0] o_ifu_rsp_data,
    input  logic              i_lsu_req_valid,
    output logic              o_lsu_req_ready,
    input  logic [ADDR_W-1:0] i_lsu_req_addr,
    input  logic              i_lsu_req_wr,
    input  logic [3:0]        i_lsu_req_mask,
    input  logic [DATA_W-1:0] i_lsu_req_data,
    output logic              o_lsu_rsp_valid,
    output logic [DATA_W-1:0] o_lsu_rsp_data,
    output logic              o_ram_rd_en,
    output logic [ADDR_W-1:0] o_ram_rd_addr,
    input  logic [DATA_W-1:0] i_ram_rd_data,
    output logic              o_ram_wr_en,
    output logic [ADDR_W-1:0] o_ram_wr_addr,
    output logic [DATA_W-1:0] o_ram_wr_data
);

    ram_arb_state_e    state_q, state_d;
    logic [1:0]        req, gnt;
    logic              in_rmw;
    logic              ifu_go, lsu_go;
    logic              lsu_rd, lsu_fw, lsu_nw, lsu_pw;
    logic [DATA_W-1:0] rmw_data_q, rmw_data_d;
    logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
    logic              ifu_vld_q, ifu_vld_d;
    logic [DATA_W-1:0] ifu_dat_q, ifu_dat_d;
    logic              lsu_vld_q, lsu_vld_d;
    logic [DATA_W-1:0] lsu_dat_q, lsu_dat_d;

    assign in_rmw = (state_q == RMW_WR);
    // Requests are masked in reset too, so nothing is granted while held.
    assign req = {i_lsu_req_valid, i_ifu_req_valid}
               & {2{~in_rmw & i_sys_rst_n}};

    arb_rr2 u_arb (
        .clk_i  (i_sys_clk),
        .rst_ni (i_sys_rst_n),
        .req_i  (req),
        .adv_i  (|gnt),
        .gnt_o  (gnt)
    );

    assign ifu_go = gnt[0];
    assign lsu_go = gnt[1];
    assign o_ifu_req_ready = ifu_go;
    assign o_lsu_req_ready = lsu_go;

    assign lsu_rd = lsu_go & ~i_lsu_req_wr;
    assign lsu_fw = lsu_go & i_lsu_req_wr & (i_lsu_req_mask == MASK_FULL);
    assign lsu_nw = lsu_go & i_lsu_req_wr & (i_lsu_req_mask == MASK_NONE);
    assign lsu_pw = lsu_go & i_lsu_req_wr & ~lsu_fw & ~lsu_nw;

    assign o_ram_rd_en   = ifu_go | lsu_rd | lsu_pw;
    assign o_ram_rd_addr = ifu_go ? i_ifu_req_addr
                         : (lsu_rd | lsu_pw) ? i_lsu_req_addr : '0;

    assign o_ram_wr_en   = in_rmw | lsu_fw;
    assign o_ram_wr_addr = in_rmw ? rmw_addr_q
                         : lsu_fw ? i_lsu_req_addr : '0;
    assign o_ram_wr_data = in_rmw ? rmw_data_q
                         : lsu_fw ? i_lsu_req_data : `DATA_ZERO;

    always_comb begin
        state_d    = state_q;
        rmw_data_d = rmw_data_q;
        rmw_addr_d = rmw_addr_q;
        if (in_rmw) begin
            state_d = IDLE;
        end else if (lsu_pw) begin
            state_d    = RMW_WR;
            rmw_data_d = byte_merge(i_ram_rd_data, i_lsu_req_data,
                                    i_lsu_req_mask);
            rmw_addr_d = i_lsu_req_addr;
        end
    end

    always_comb begin
        ifu_vld_d = ifu_go;
        ifu_dat_d = ifu_go ? i_ram_rd_data : ifu_dat_q;
        lsu_vld_d = lsu_rd | lsu_fw | lsu_nw | in_rmw;
        lsu_dat_d = lsu_dat_q;
        if (lsu_rd)                          lsu_dat_d = i_ram_rd_data;
        else if (lsu_fw | lsu_nw | in_rmw)   lsu_dat_d = `DATA_ZERO;
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q    <= IDLE;
            rmw_data_q <= `DATA_ZERO;
            rmw_addr_q <= '0;
            ifu_vld_q  <= 1'b0;
            ifu_dat_q  <= `DATA_ZERO;
            lsu_vld_q  <= 1'b0;
            lsu_dat_q  <= `DATA_ZERO;
        end else begin
            state_q    <= state_d;
            rmw_data_q <= rmw_data_d;
            rmw_addr_q <= rmw_addr_d;
            ifu_vld_q  <= ifu_vld_d;
            ifu_dat_q  <= ifu_dat_d;
            lsu_vld_q  <= lsu_vld_d;
            lsu_dat_q  <= lsu_dat_d;
        end
    end

    assign o_ifu_rsp_valid = ifu_vld_q;
    assign o_ifu_rsp_data  = ifu_dat_q;
    assign o_lsu_rsp_valid = lsu_vld_q;
    assign o_lsu_rsp_data  = lsu_dat_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with a queue-based scoreboard;
// a negedge monitor checks response data and arrival cycle.
module tb_ram_arbiter;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_valid, ifu_ready, ifu_rsp_valid;
    logic [31:0] ifu_addr, ifu_rsp_data;
    logic        lsu_valid, lsu_ready, lsu_wr, lsu_rsp_valid;
    logic [3:0]  lsu_mask;
    logic [31:0] lsu_addr, lsu_data, lsu_rsp_data;
    logic        rd_en, wr_en;
    logic [31:0] rd_addr, rd_data, wr_addr, wr_data;

    logic [31:0] mem [256];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_dat;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        q_ifu[$];
    exp_t        q_lsu[$];

    ram_arbiter dut (
        .i_sys_clk       (clk),
        .i_sys_rst_n     (rst_n),
        .i_ifu_req_valid (ifu_valid),
        .o_ifu_req_ready (ifu_ready),
        .i_ifu_req_addr  (ifu_addr),
        .o_ifu_rsp_valid (ifu_rsp_valid),
        .o_ifu_rsp_data  (ifu_rsp_data),
        .i_lsu_req_valid (lsu_valid),
        .o_lsu_req_ready (lsu_ready),
        .i_lsu_req_addr  (lsu_addr),
        .i_lsu_req_wr    (lsu_wr),
        .i_lsu_req_mask  (lsu_mask),
        .i_lsu_req_data  (lsu_data),
        .o_lsu_rsp_valid (lsu_rsp_valid),
        .o_lsu_rsp_data  (lsu_rsp_data),
        .o_ram_rd_en     (rd_en),
        .o_ram_rd_addr   (rd_addr),
        .i_ram_rd_data   (rd_data),
        .o_ram_wr_en     (wr_en),
        .o_ram_wr_addr   (wr_addr),
        .o_ram_wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign rd_data = mem[rd_addr[9:2]];

    always @(posedge clk) begin
        if (pre_we)     mem[pre_idx] <= pre_dat;
        else if (wr_en) mem[wr_addr[9:2]] <= wr_data;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        pre_we = 1'b1; pre_idx = idx; pre_dat = d;
        step();
        pre_we = 1'b0;
    endtask

    task automatic push_ifu(input int unsigned lat, input logic [31:0] d);
        exp_t e;
        e.cyc = cyc + lat; e.data = d;
        q_ifu.push_back(e);
    endtask

    task automatic push_lsu(input int unsigned lat, input logic [31:0] d);
        exp_t e;
        e.cyc = cyc + lat; e.data = d;
        q_lsu.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ifu_rsp_valid) begin
            if (q_ifu.size() == 0) begin
                chk("ifu_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = q_ifu.pop_front();
                chk("ifu_rsp_cycle", cyc, e.cyc);
                chk("ifu_rsp_data", ifu_rsp_data, e.data);
            end
        end
        if (rst_n && lsu_rsp_valid) begin
            if (q_lsu.size() == 0) begin
                chk("lsu_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = q_lsu.pop_front();
                chk("lsu_rsp_cycle", cyc, e.cyc);
                chk("lsu_rsp_data", lsu_rsp_data, e.data);
            end
        end
    end

    initial begin
        rst_n = 1'b0; pre_we = 1'b0; pre_idx = '0; pre_dat = '0;
        ifu_valid = 1'b1; ifu_addr = 32'h4;
        lsu_valid = 1'b1; lsu_addr = '0; lsu_wr = 1'b0;
        lsu_mask = '0; lsu_data = '0;
        preload(8'd1,  32'hDEAD_BEEF);
        preload(8'd4,  32'h1122_3344);
        preload(8'd8,  32'h0000_0000);
        preload(8'd12, 32'h5555_5555);

        // reset values with both requesters valid
        @(negedge clk);
        chk("rst_ifu_ready", {31'd0, ifu_ready}, 32'd0);
        chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        chk("rst_ifu_rsp_valid", {31'd0, ifu_rsp_valid}, 32'd0);
        chk("rst_lsu_rsp_valid", {31'd0, lsu_rsp_valid}, 32'd0);
        chk("rst_ifu_rsp_data", ifu_rsp_data, 32'd0);
        chk("rst_lsu_rsp_data", lsu_rsp_data, 32'd0);
        chk("rst_ram_en", {30'd0, rd_en, wr_en}, 32'd0);
        chk("rst_ram_wr_data", wr_data, 32'd0);
        ifu_valid = 1'b0; lsu_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // IFU read of 0x4
        ifu_valid = 1'b1; ifu_addr = 32'h4;
        @(negedge clk);
        chk("t1_ifu_ready", {31'd0, ifu_ready}, 32'd1);
        chk("t1_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        chk("t1_rd_en", {31'd0, rd_en}, 32'd1);
        chk("t1_rd_addr", rd_addr, 32'h4);
        push_ifu(1, 32'hDEAD_BEEF);
        step();
        ifu_valid = 1'b0;
        step(); step();

        // fresh reset so the pointer starts at IFU
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // both valid for 4 cycles: IFU, LSU, IFU, LSU
        ifu_valid = 1'b1; ifu_addr = 32'h4;
        lsu_valid = 1'b1; lsu_addr = 32'h10; lsu_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_ifu_ready", {31'd0, ifu_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_lsu_ready", {31'd0, lsu_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 0) push_ifu(1, 32'hDEAD_BEEF);
            else            push_lsu(1, 32'h1122_3344);
            step();
        end
        ifu_valid = 1'b0; lsu_valid = 1'b0;
        step();

        // partial write mask 0101 to 0x10, IFU waits out RMW_WR
        lsu_valid = 1'b1; lsu_addr = 32'h10; lsu_wr = 1'b1;
        lsu_mask = 4'b0101; lsu_data = 32'hAABB_CCDD;
        @(negedge clk);
        chk("t3_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        chk("t3_grant_wr_en", {31'd0, wr_en}, 32'd0);
        push_lsu(2, 32'h0);
        step();
        lsu_valid = 1'b0;
        ifu_valid = 1'b1; ifu_addr = 32'h10;
        @(negedge clk);
        chk("t3_rmw_ifu_ready", {31'd0, ifu_ready}, 32'd0);
        chk("t3_rmw_wr_en", {31'd0, wr_en}, 32'd1);
        chk("t3_rmw_wr_addr", wr_addr, 32'h10);
        chk("t3_rmw_wr_data", wr_data, 32'h11BB_33DD);
        step();
        @(negedge clk);
        chk("t3_ifu_ready_after", {31'd0, ifu_ready}, 32'd1);
        push_ifu(1, 32'h11BB_33DD);
        step();
        ifu_valid = 1'b0;
        step();

        // full write then IFU read-after-write
        lsu_valid = 1'b1; lsu_addr = 32'h20; lsu_wr = 1'b1;
        lsu_mask = 4'b1111; lsu_data = 32'hCAFE_F00D;
        @(negedge clk);
        chk("t4_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        chk("t4_wr_en", {31'd0, wr_en}, 32'd1);
        chk("t4_rd_en", {31'd0, rd_en}, 32'd0);
        push_lsu(1, 32'h0);
        step();
        lsu_valid = 1'b0;
        ifu_valid = 1'b1; ifu_addr = 32'h20;
        @(negedge clk);
        chk("t4_ifu_ready", {31'd0, ifu_ready}, 32'd1);
        push_ifu(1, 32'hCAFE_F00D);
        step();
        ifu_valid = 1'b0;
        step();

        // null write to 0x30
        lsu_valid = 1'b1; lsu_addr = 32'h30; lsu_wr = 1'b1;
        lsu_mask = 4'b0000; lsu_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("t5_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        chk("t5_ram_en", {30'd0, rd_en, wr_en}, 32'd0);
        push_lsu(1, 32'h0);
        step();
        lsu_valid = 1'b0;
        @(negedge clk);
        chk("t5_wr_en_after", {31'd0, wr_en}, 32'd0);
        chk("t5_mem_0x30", mem[12], 32'h5555_5555);
        step();

        // reset asserted during RMW_WR drops the write and the ack
        lsu_valid = 1'b1; lsu_addr = 32'h30; lsu_wr = 1'b1;
        lsu_mask = 4'b0011; lsu_data = 32'h0;
        @(negedge clk);
        chk("t6_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        step();
        lsu_valid = 1'b0;
        chk("t6_rmw_wr_en", {31'd0, wr_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wr_en", {31'd0, wr_en}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("t6_mem_0x30", mem[12], 32'h5555_5555);
        chk("t6_ifu_rsp_data", ifu_rsp_data, 32'd0);
        chk("t6_lsu_rsp_data", lsu_rsp_data, 32'd0);
        chk("t6_rsp_valid", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
        chk("t6_ram_en", {30'd0, rd_en, wr_en}, 32'd0);
        step();
        ifu_valid = 1'b1; ifu_addr = 32'h30;
        lsu_valid = 1'b1; lsu_addr = 32'h4; lsu_wr = 1'b0;
        @(negedge clk);
        chk("t6_ptr_ifu_ready", {31'd0, ifu_ready}, 32'd1);
        chk("t6_ptr_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        push_ifu(1, 32'h5555_5555);
        step();
        ifu_valid = 1'b0; lsu_valid = 1'b0;
        step(); step(); step();

        chk("ifu_queue_drained", q_ifu.size(), 32'd0);
        chk("lsu_queue_drained", q_lsu.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester controller that shares the single data/instruction `ram` between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It arbitrates round-robin, drives the RAM's read and write ports, and returns one registered response per accepted request. The RAM has no byte enables, so the arbiter turns partial-word stores into a read-modify-write sequence. It sits between the IFU/LSU and the `ram` instance.

## Interface
- `ADDR_W`, default `` `ADDR_WIDTH ``: address width.
- `DATA_W`, default `` `DATA_WIDTH ``: data width; fixed at 32, byte mask is `DATA_W/8` = 4 bits.
- `i_sys_clk` in 1: single clock, all state on the rising edge.
- `i_sys_rst_n` in 1: asynchronous, active-low reset.
- `i_ifu_req_valid` in 1, `o_ifu_req_ready` out 1, `i_ifu_req_addr` in ADDR_W: IFU read request.
- `o_ifu_rsp_valid` out 1, `o_ifu_rsp_data` out DATA_W: IFU read response.
- `i_lsu_req_valid` in 1, `o_lsu_req_ready` out 1, `i_lsu_req_addr` in ADDR_W: LSU request handshake and address.
- `i_lsu_req_wr` in 1, `i_lsu_req_mask` in 4, `i_lsu_req_data` in DATA_W: LSU write flag, byte mask and write data.
- `o_lsu_rsp_valid` out 1, `o_lsu_rsp_data` out DATA_W: LSU response.
- `o_ram_rd_en` out 1, `o_ram_rd_addr` out ADDR_W, `i_ram_rd_data` in DATA_W: RAM read port; RAM read is combinational.
- `o_ram_wr_en` out 1, `o_ram_wr_addr` out ADDR_W, `o_ram_wr_data` out DATA_W: RAM write port; RAM writes on the clock edge.

## Operation
- FSM states: `IDLE` and `RMW_WR`.
- **Arbitration (`IDLE` only):**
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the side named by the round-robin pointer.
  - The pointer moves to the other side after every grant.
  - `o_*_req_ready` is combinational and is high only for the granted side in `IDLE`. The handshake is valid & ready.
- **Read** (IFU, or LSU with `wr`=0):
  - In the grant cycle: `o_ram_rd_en`=1, `o_ram_rd_addr`=request address.
  - `i_ram_rd_data` is registered into that side's `rsp_data`.
- **LSU full write** (mask 4'b1111): `o_ram_wr_en`=1 in the grant cycle with address and data. Response data is zero.
- **LSU null write** (mask 4'b0000): no RAM access; response is still returned, data zero.
- **LSU partial write** (any other mask):
  - Grant cycle: read the RAM word, merge byte-wise (mask bit i selects `req_data[8i+7:8i]`, otherwise the RAM byte), latch the merged word and address, go to `RMW_WR`.
  - `RMW_WR`: write the latched word, both readies low, return to `IDLE`.
- Address bits [1:0] are passed through unchanged; the RAM ignores them (word access only).
- Responses have no backpressure: requesters must accept `rsp_valid` whenever it is asserted.
- `rsp_valid` is a one-cycle pulse. `rsp_data` holds its value until the next response on that side.

## Timing
- Read latency: `rsp_valid` in the cycle after the handshake.
- Full or null write latency: ack the cycle after the handshake.
- Partial write latency: ack the cycle after `RMW_WR`, i.e. 2 cycles after the handshake. Next grant is possible in that same ack cycle.
- Throughput: one grant per cycle in `IDLE`. A partial write costs 2 cycles.
- Read-after-write: a read granted the cycle after a write (or after `RMW_WR`) sees the new data, because the RAM writes on the edge.
- RAM port outputs are combinational from state and grant. When idle they drive zero: en=0, addr=0, data=`` `DATA_ZERO ``.
- Reset values:
  - State `IDLE`; pointer = IFU.
  - Both `rsp_valid`=0, both `rsp_data`=`` `DATA_ZERO ``.
  - Both readies 0 while reset is asserted.
  - RMW latch cleared.
- Reset asserted during `RMW_WR`: the write is dropped (`o_ram_wr_en` falls immediately) and no ack is issued.
- A requester dropping `valid` without a handshake is legal and has no effect.

## Structure
- Shared package `mem_pkg`:
  - State enum `ram_arb_state_e` {`IDLE`, `RMW_WR`}.
  - Mask constants `MASK_FULL`=4'b1111, `MASK_NONE`=4'b0000.
  - Function `byte_merge(old, new, mask)`.
- Sub-module `arb_rr2`: two-way round-robin arbiter. Inputs: 2 requests and an advance strobe. Outputs: one-hot grant. Holds the pointer flop.
- All other logic lives in `ram_arbiter`.

## Test plan
- Reset, then IFU read of 0x0000_0004 holding 0xDEAD_BEEF: ready the same cycle; `o_ifu_rsp_valid`=1 next cycle with 0xDEAD_BEEF; LSU outputs stay 0.
- IFU and LSU both valid continuously for 4 cycles, pointer at IFU after reset: grants IFU, LSU, IFU, LSU; every response arrives exactly one cycle after its grant.
- Word 0x1122_3344 at 0x10; LSU write 0xAABB_CCDD with mask 4'b0101: ack at +2; a subsequent read returns 0x11BB_33DD; IFU held off during `RMW_WR`.
- LSU full write 0xCAFE_F00D to 0x20, then IFU read of 0x20 the next cycle: returns 0xCAFE_F00D.
- LSU write with mask 4'b0000 to 0x30 (old 0x5555_5555): ack next cycle, `o_ram_wr_en` never high, word unchanged.
- Assert `i_sys_rst_n`=0 in the `RMW_WR` cycle: no RAM write, no ack; after release all outputs are at reset values and the pointer is at IFU.
